// File: rtl/alu_pkg.sv
// Shared definitions for the 10-bit ALU datapath.
// ALU_WIDTH is the default operand width for the arithmetic core;
// alu_word_t is the matching operand/result word type.
package alu_pkg;

    localparam int ALU_WIDTH = 10;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// Single-bit full-adder cell: the building block of the ripple-carry chain.
// Purely combinational; the carry out feeds the next more-significant cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_w;

    // Propagate term is shared by the sum and carry equations.
    always_comb begin
        p_w = a ^ b;
        s   = p_w ^ ci;
        co  = (a & b) | (ci & p_w);
    end

endmodule : full_adder

// File: rtl/rca_adder_10.sv
// Registered WIDTH-bit ripple-carry adder: {cout,sum} = A + B + cin,
// one pipeline stage. Subtraction is done by the caller as A + ~B + 1.
// The carry ripples through WIDTH chained full_adder cells (no lookahead).
// Optional feature macro: RCA_ADDER_OVF_EN adds a registered signed-overflow
// output ovf = c[WIDTH] ^ c[WIDTH-1].
module rca_adder_10
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Carry vector: c[0] is the carry in, c[WIDTH] the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_w;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             valid_d;
    logic             valid_q;
`ifdef RCA_ADDER_OVF_EN
    logic             ovf_d;
    logic             ovf_q;
`endif

    assign c[0] = cin;

    // Ripple chain, LSB to MSB; each cell consumes the previous cell's carry.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .a  (A[gi]),
                .b  (B[gi]),
                .ci (c[gi]),
                .s  (s_w[gi]),
                .co (c[gi+1])
            );
        end
    endgenerate

    // Next-state: capture a new result on accepted input, otherwise hold it;
    // out_valid simply follows in_valid one cycle later.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
`ifdef RCA_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            sum_d  = s_w;
            cout_d = c[WIDTH];
`ifdef RCA_ADDER_OVF_EN
            // Signed overflow: carry into the sign bit differs from carry out.
            ovf_d  = c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end

    // Output register stage; reset clears results immediately and discards
    // any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef RCA_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef RCA_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
`ifdef RCA_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : rca_adder_10

// File: tb/tb_rca_adder_10.sv
// Self-checking bench for rca_adder_10 (WIDTH=10). Expected results come from
// integer arithmetic on the operands; define RCA_ADDER_OVF_EN to also check ovf.
module tb_rca_adder_10;

    localparam int W   = 10;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_o;

    int vectors     = 0;
    int miscompares = 0;

    // Last accepted result {cout, sum, ovf}, for hold checks.
    logic [W+1:0] held;

    rca_adder_10 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
`ifdef RCA_ADDER_OVF_EN
        ,
        .ovf       (ovf_o)
`endif
    );

`ifndef RCA_ADDER_OVF_EN
    assign ovf_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: {cout, sum, ovf} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input int a, input int b, input int ci);
        int total, sa, sb, sr;
        logic co, ov;
        logic [W-1:0] s;
        total = a + b + ci;
        s  = W'(total % MOD);
        co = (total >= MOD);
        sa = (a >= MOD / 2) ? a - MOD : a;
        sb = (b >= MOD / 2) ? b - MOD : b;
        sr = sa + sb + ci;
        ov = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
`ifndef RCA_ADDER_OVF_EN
        ov = 1'b0;
`endif
        return {co, s, ov};
    endfunction

    task automatic drive(input logic v, input int a, input int b, input logic ci);
        @(negedge clk);
        in_valid = v;
        A   = W'(a);
        B   = W'(b);
        cin = ci;
    endtask

    task automatic test_reset;
        logic [W+2:0] obs;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {out_valid, cout, sum, ovf_o};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=0", obs);
        end
        drive(1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        held = '0;
    endtask

    // Directed vectors from the arithmetic rules, including wrap and max cases.
    task automatic test_directed;
        int da[8]  = '{15, 20, 5,    1023, 1023, 511, 1023, 0};
        int db[8]  = '{10, 1015, 1013, 0,  1023, 1,   1,    0};
        int dc[8]  = '{0,  1,  1,    1,    1,    0,   0,    0};
        logic [W+1:0] exp;
        logic [W+2:0] obs;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, da[i], db[i], dc[i][0]);
            exp = model(da[i], db[i], dc[i]);
            @(posedge clk); #1;
            obs = {out_valid, cout, sum, ovf_o};
            vectors++;
            $display("vec a=%0d b=%0d cin=%0d -> cout=%0b sum=%0d ovf=%0b",
                     da[i], db[i], dc[i], cout, sum, ovf_o);
            if (obs !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL directed_%0d got=%h exp=%h", i, obs, {1'b1, exp});
            end
            held = exp;
        end
        // Spot values stated directly in the arithmetic description.
        drive(1'b1, 15, 10, 1'b0);
        @(posedge clk); #1;
        vectors++;
        if (sum !== 10'd25 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL add_15_10 got sum=%0d cout=%0b exp sum=25 cout=0", sum, cout);
        end
        drive(1'b1, 1023, 1023, 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (sum !== 10'd1023 || cout !== 1'b1) begin
            miscompares++;
            $display("FAIL max_case got sum=%0d cout=%0b exp sum=1023 cout=1", sum, cout);
        end
`ifdef RCA_ADDER_OVF_EN
        drive(1'b1, 511, 1, 1'b0);
        @(posedge clk); #1;
        vectors++;
        if (sum !== 10'd512 || ovf_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_511_1 got sum=%0d ovf=%0b exp sum=512 ovf=1", sum, ovf_o);
        end
`endif
        held = model(1023, 1023, 1);
`ifdef RCA_ADDER_OVF_EN
        held = model(511, 1, 0);
`endif
    endtask

    // Random subtracts: cout must report A >= B (unsigned).
    task automatic test_subtract;
        int a, b;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(MOD - 1, 0));
            b = (i % 8 == 0) ? a : int'($urandom_range(MOD - 1, 0));
            drive(1'b1, a, (~b) & (MOD - 1), 1'b1);
            @(posedge clk); #1;
            vectors++;
            if (sum !== W'((a - b + MOD) % MOD) || cout !== (a >= b)) begin
                miscompares++;
                $display("FAIL sub a=%0d b=%0d got sum=%0d cout=%0b exp sum=%0d cout=%0b",
                         a, b, sum, cout, (a - b + MOD) % MOD, (a >= b));
            end
            held = model(a, (~b) & (MOD - 1), 1);
        end
    endtask

    // Random stream with random bubbles: bubbles must hold the last result.
    task automatic test_random;
        int a, b, ci;
        logic v;
        logic [W+2:0] obs, exp;
        for (int i = 0; i < 300; i++) begin
            a  = int'($urandom_range(MOD - 1, 0));
            b  = int'($urandom_range(MOD - 1, 0));
            ci = int'($urandom_range(1, 0));
            v  = ($urandom_range(3, 0) != 0);
            drive(v, a, b, ci[0]);
            if (v) held = model(a, b, ci);
            exp = {v, held};
            @(posedge clk); #1;
            obs = {out_valid, cout, sum, ovf_o};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random_%0d v=%0b a=%0d b=%0d cin=%0d got=%h exp=%h",
                         i, v, a, b, ci, obs, exp);
            end
        end
    endtask

    // Three consecutive valid vectors, then idle: no bubbles, then hold.
    task automatic test_back_to_back;
        int a[3], b[3];
        logic [W+2:0] obs;
        for (int i = 0; i < 3; i++) begin
            a[i] = int'($urandom_range(MOD - 1, 0));
            b[i] = int'($urandom_range(MOD - 1, 0));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, a[i], b[i], 1'b0);
            @(posedge clk); #1;
            obs = {out_valid, cout, sum, ovf_o};
            vectors++;
            if (obs !== {1'b1, model(a[i], b[i], 0)}) begin
                miscompares++;
                $display("FAIL stream_%0d got=%h exp=%h", i, obs, {1'b1, model(a[i], b[i], 0)});
            end
        end
        held = model(a[2], b[2], 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1023, 1023, 1'b1);
            @(posedge clk); #1;
            obs = {out_valid, cout, sum, ovf_o};
            vectors++;
            if (obs !== {1'b0, held}) begin
                miscompares++;
                $display("FAIL hold_%0d got=%h exp=%h", i, obs, {1'b0, held});
            end
        end
    endtask

    // Asynchronous reset mid-cycle discards the pending result.
    task automatic test_async_reset;
        logic [W+2:0] obs;
        drive(1'b1, 100, 200, 1'b0);
        @(posedge clk); #1;
        vectors++;
        if (sum !== 10'd300 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset got sum=%0d ov=%0b exp sum=300 ov=1", sum, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        obs = {out_valid, cout, sum, ovf_o};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=0", obs);
        end
        @(posedge clk); #1;
        obs = {out_valid, cout, sum, ovf_o};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_held got=%h exp=0", obs);
        end
        drive(1'b0, 100, 200, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {out_valid, cout, sum, ovf_o};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle got=%h exp=0", obs);
        end
        drive(1'b1, 7, 9, 1'b1);
        @(posedge clk); #1;
        obs = {out_valid, cout, sum, ovf_o};
        vectors++;
        if (obs !== {1'b1, model(7, 9, 1)}) begin
            miscompares++;
            $display("FAIL first_after_reset got=%h exp=%h", obs, {1'b1, model(7, 9, 1)});
        end
        drive(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_subtract();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_rca_adder_10
